// File: rtl/urv_pipe_ctrl.sv
// urv_pipe_ctrl: per-stage stall/kill, RUN/HALT/WFI state machine and interrupt take logic for uRV.
// Define URV_PIPE_CTRL_IRQ_SYNC_EN to pass nIRQ/nNMI through 2-flop synchronisers.
module urv_pipe_ctrl #(
  parameter int G_STAGES    = 4,
  parameter int G_BRA_STAGE = 2,
  parameter int G_IRQ_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [G_STAGES-1:0]    stall_req_i,
  input  logic                   bra_i,
  input  logic                   trap_req_i,
  input  logic                   wfi_req_i,
  input  logic                   dbg_halt_i,
  input  logic                   dbg_resume_i,
  input  logic [G_IRQ_WIDTH-1:0] nIRQ,
  input  logic                   nNMI,
  input  logic [G_IRQ_WIDTH-1:0] irq_mask_i,
  input  logic                   irq_enable_i,
  output logic [G_STAGES-1:0]    stall_o,
  output logic [G_STAGES-1:0]    kill_o,
  output logic [1:0]             cpu_state_o,
  output logic                   TRAP,
  output logic [G_IRQ_WIDTH-1:0] irq_pending_o,
  output logic                   irq_take_o,
  output logic [4:0]             irq_id_o,
  output logic                   nmi_take_o
);
  typedef enum logic [1:0] {S_RUN = 2'b00, S_HALT = 2'b01, S_WFI = 2'b10} state_t;
  state_t                 state_q, state_d;
  logic [G_BRA_STAGE-1:0] shadow_q, shadow_d;
  logic [G_IRQ_WIDTH-1:0] irq_pend_q, irq_pend_d, nirq_s;
  logic                   nmi_pend_q, nmi_pend_d, nmi_prev_q, nnmi_s;
  logic                   irq_take_q, irq_take_d, nmi_take_q, nmi_take_d;
  logic [4:0]             irq_id_q, irq_id_d;
  logic                   stall_acc, kill_acc, take_ok;

  assign TRAP          = state_q != S_RUN;
  assign cpu_state_o   = state_q;
  assign irq_pending_o = irq_pend_q;
  assign irq_take_o    = irq_take_q;
  assign irq_id_o      = irq_id_q;
  assign nmi_take_o    = nmi_take_q;

`ifdef URV_PIPE_CTRL_IRQ_SYNC_EN
  logic [G_IRQ_WIDTH-1:0] nirq_m_q, nirq_s_q;
  logic                   nnmi_m_q, nnmi_s_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      nirq_m_q <= '1;
      nirq_s_q <= '1;
      nnmi_m_q <= 1'b1;
      nnmi_s_q <= 1'b1;
    end else begin
      nirq_m_q <= nIRQ;
      nirq_s_q <= nirq_m_q;
      nnmi_m_q <= nNMI;
      nnmi_s_q <= nnmi_m_q;
    end
  end
  assign nirq_s = nirq_s_q;
  assign nnmi_s = nnmi_s_q;
`else
  assign nirq_s = nIRQ;
  assign nnmi_s = nNMI;
`endif

  // A stage stalls when any later stage stalls; its own request is not fed back.
  always_comb begin
    stall_o   = '0;
    stall_acc = TRAP;
    for (int i = G_STAGES - 2; i >= 0; i--) begin
      stall_acc  = stall_acc | stall_req_i[i+1];
      stall_o[i] = stall_acc;
    end
  end

  always_comb begin
    kill_o    = '0;
    kill_acc  = bra_i;
    kill_o[0] = bra_i;
    for (int i = 1; i <= G_BRA_STAGE; i++) begin
      kill_acc  = kill_acc | shadow_q[i-1];
      kill_o[i] = kill_acc;
    end
    shadow_d    = shadow_q;
    shadow_d[0] = bra_i;
    for (int k = 1; k < G_BRA_STAGE; k++) shadow_d[k] = shadow_q[k-1];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   state_d = (trap_req_i | dbg_halt_i) ? S_HALT : wfi_req_i ? S_WFI : S_RUN;
      S_WFI:   state_d = dbg_halt_i ? S_HALT : (|irq_pend_q | nmi_pend_q) ? S_RUN : S_WFI;
      S_HALT:  state_d = (dbg_resume_i & ~dbg_halt_i) ? S_RUN : S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // Blocking on the previous cycle's takes leaves a one-cycle gap between them.
  always_comb begin
    take_ok    = (state_q == S_RUN) & ~|kill_o & ~stall_o[G_BRA_STAGE] & ~irq_take_q & ~nmi_take_q;
    nmi_take_d = take_ok & nmi_pend_q;
    irq_take_d = take_ok & ~nmi_pend_q & irq_enable_i & |irq_pend_q;
    nmi_pend_d = (nmi_prev_q & ~nnmi_s) | (nmi_pend_q & ~nmi_take_q);
    irq_pend_d = ~nirq_s & irq_mask_i;
    irq_id_d   = irq_id_q;
    for (int i = G_IRQ_WIDTH - 1; i >= 0; i--) if (irq_pend_q[i]) irq_id_d = 5'(i);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_RUN;
      shadow_q   <= '0;
      irq_pend_q <= '0;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
      irq_take_q <= 1'b0;
      nmi_take_q <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      if (!stall_o[G_BRA_STAGE]) shadow_q <= shadow_d;
      irq_pend_q <= irq_pend_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nnmi_s;
      irq_take_q <= irq_take_d;
      nmi_take_q <= nmi_take_d;
      if (irq_take_d) irq_id_q <= irq_id_d;
    end
  end
endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// tb_urv_pipe_ctrl: directed-vector bench for urv_pipe_ctrl with G_STAGES=4, G_BRA_STAGE=2, 32 IRQs.
module tb_urv_pipe_ctrl;
`ifdef URV_PIPE_CTRL_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic        CLK = 1'b0, nRST = 1'b0;
  logic [3:0]  stall_req_i = '0;
  logic        bra_i = 0, trap_req_i = 0, wfi_req_i = 0, dbg_halt_i = 0, dbg_resume_i = 0;
  logic [31:0] nIRQ = '1, irq_mask_i = '0;
  logic        nNMI = 1'b1, irq_enable_i = 1'b0;
  logic [3:0]  stall_o, kill_o;
  logic [1:0]  cpu_state_o;
  logic        TRAP, irq_take_o, nmi_take_o;
  logic [31:0] irq_pending_o;
  logic [4:0]  irq_id_o;
  int          n_chk = 0, n_fail = 0;

  urv_pipe_ctrl #(.G_STAGES(4), .G_BRA_STAGE(2), .G_IRQ_WIDTH(32)) dut (
    .CLK(CLK), .nRST(nRST), .stall_req_i(stall_req_i), .bra_i(bra_i), .trap_req_i(trap_req_i),
    .wfi_req_i(wfi_req_i), .dbg_halt_i(dbg_halt_i), .dbg_resume_i(dbg_resume_i), .nIRQ(nIRQ),
    .nNMI(nNMI), .irq_mask_i(irq_mask_i), .irq_enable_i(irq_enable_i), .stall_o(stall_o),
    .kill_o(kill_o), .cpu_state_o(cpu_state_o), .TRAP(TRAP), .irq_pending_o(irq_pending_o),
    .irq_take_o(irq_take_o), .irq_id_o(irq_id_o), .nmi_take_o(nmi_take_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc;
    @(negedge CLK);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " state"}, 32'(cpu_state_o), 32'h0);
    chk({tag, " trap"}, 32'(TRAP), 32'h0);
    chk({tag, " stall"}, 32'(stall_o), 32'h0);
    chk({tag, " kill"}, 32'(kill_o), 32'h0);
    chk({tag, " pend"}, irq_pending_o, 32'h0);
    chk({tag, " irq_take"}, 32'(irq_take_o), 32'h0);
    chk({tag, " nmi_take"}, 32'(nmi_take_o), 32'h0);
    chk({tag, " irq_id"}, 32'(irq_id_o), 32'h0);
  endtask

  initial begin
    #12 chk_idle("reset");
    cyc; nRST = 1'b1;
    // branch kill sweep
    cyc; bra_i = 1; #1 chk("kill c0", 32'(kill_o), 32'h7);
    cyc; bra_i = 0; #1 chk("kill c1", 32'(kill_o), 32'h6);
    cyc; chk("kill c2", 32'(kill_o), 32'h4);
    cyc; chk("kill c3", 32'(kill_o), 32'h0);
    // stall propagation, no self feedback
    stall_req_i = 4'b0100; #1 chk("stall 0100", 32'(stall_o), 32'h3);
    cyc; chk("stall held", 32'(stall_o), 32'h3);
    cyc; chk("stall wb", 32'(stall_o[3]), 32'h0);
    stall_req_i = 4'b0000;
    // shadow freezes while the branch stage is stalled
    cyc; bra_i = 1;
    cyc; bra_i = 0; stall_req_i = 4'b1000; #1 chk("stall 1000", 32'(stall_o), 32'h7);
    chk("frz kill0", 32'(kill_o), 32'h6);
    cyc; chk("frz kill1", 32'(kill_o), 32'h6);
    cyc; chk("frz kill2", 32'(kill_o), 32'h6); stall_req_i = 4'b0000;
    cyc; chk("unfrz kill", 32'(kill_o), 32'h4);
    cyc; chk("unfrz kill2", 32'(kill_o), 32'h0);
    // trap -> HALT -> resume
    trap_req_i = 1;
    cyc; trap_req_i = 0; #1 chk("trap state", 32'(cpu_state_o), 32'h1);
    chk("trap TRAP", 32'(TRAP), 32'h1);
    chk("trap stall", 32'(stall_o), 32'h7);
    dbg_halt_i = 1; dbg_resume_i = 1;
    cyc; chk("resume blocked", 32'(cpu_state_o), 32'h1);
    dbg_halt_i = 0;
    cyc; dbg_resume_i = 0; #1 chk("resume", 32'(cpu_state_o), 32'h0);
    chk("resume TRAP", 32'(TRAP), 32'h0);
    // WFI wake on masked IRQ and take
    irq_mask_i = 32'h20; irq_enable_i = 1; wfi_req_i = 1;
    cyc; wfi_req_i = 0; #1 chk("wfi state", 32'(cpu_state_o), 32'h2);
    chk("wfi TRAP", 32'(TRAP), 32'h1);
    nIRQ[5] = 0;
    repeat (LAT) cyc;
    chk("wfi pend", irq_pending_o, 32'h20);
    chk("wfi still", 32'(cpu_state_o), 32'h2);
    cyc; chk("wake", 32'(cpu_state_o), 32'h0);
    chk("wake no take", 32'(irq_take_o), 32'h0);
    cyc; chk("irq take", 32'(irq_take_o), 32'h1);
    chk("irq id5", 32'(irq_id_o), 32'h5);
    nIRQ[5] = 1;
    cyc; chk("irq gap", 32'(irq_take_o), 32'h0);
    repeat (LAT) cyc;
    chk("irq clr pend", irq_pending_o, 32'h0);
    chk("irq clr take", 32'(irq_take_o), 32'h0);
    chk("irq id hold", 32'(irq_id_o), 32'h5);
    // mask and global enable
    irq_mask_i = '0; nIRQ[5] = 0;
    repeat (LAT + 1) cyc;
    chk("masked pend", irq_pending_o, 32'h0);
    chk("masked take", 32'(irq_take_o), 32'h0);
    irq_mask_i = 32'h20;
    cyc; chk("unmask pend", irq_pending_o, 32'h20);
    irq_enable_i = 0;
    cyc; chk("dis take0", 32'(irq_take_o), 32'h0);
    cyc; chk("dis take1", 32'(irq_take_o), 32'h0);
    nIRQ[5] = 1;
    repeat (LAT + 1) cyc;
    chk("dis pend clr", irq_pending_o, 32'h0);
    irq_enable_i = 1;
    // NMI beats IRQ, lowest IRQ id wins
    irq_mask_i = 32'h208; nIRQ[3] = 0; nIRQ[9] = 0; nNMI = 0;
    repeat (LAT) cyc;
    chk("nmi pend", irq_pending_o, 32'h208);
    chk("nmi pre", 32'(nmi_take_o), 32'h0);
    cyc; chk("nmi take", 32'(nmi_take_o), 32'h1);
    chk("nmi irq blk", 32'(irq_take_o), 32'h0);
    cyc; chk("nmi gap n", 32'(nmi_take_o), 32'h0);
    chk("nmi gap i", 32'(irq_take_o), 32'h0);
    cyc; chk("after nmi irq", 32'(irq_take_o), 32'h1);
    chk("after nmi id3", 32'(irq_id_o), 32'h3);
    chk("nmi once", 32'(nmi_take_o), 32'h0);
    cyc; chk("nmi no retrig", 32'(nmi_take_o), 32'h0);
    nIRQ = '1; nNMI = 1;
    repeat (LAT + 2) cyc;
    chk("nmi clr pend", irq_pending_o, 32'h0);
    // async reset with NMI pending in WFI
    wfi_req_i = 1;
    cyc; wfi_req_i = 0; nNMI = 0;
    repeat (LAT) cyc;
    chk("rst wfi", 32'(cpu_state_o), 32'h2);
    nRST = 0; nNMI = 1; #1 chk_idle("midrst");
    cyc; nRST = 1;
    for (int i = 0; i < 4; i++) begin
      cyc; chk("post rst nmi", 32'(nmi_take_o), 32'h0);
      chk("post rst state", 32'(cpu_state_o), 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
